// File: rtl/sgdmac_ar_scheduler.sv
// Round-robin arbiter sharing the SG-DMA AXI AR channel among N_REQ read requesters,
// with per-requester outstanding-burst caps and RID-based R-channel steering.
module sgdmac_ar_scheduler #(
    parameter int N_REQ    = 2,
    parameter int MAX_OUTS = 4,
    parameter int ID_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [N_REQ*41-1:0]  req_data_i,
    output logic [ID_W-1:0]      arid_o,
    output logic [31:0]          araddr_o,
    output logic [3:0]           arlen_o,
    output logic [2:0]           arsize_o,
    output logic [1:0]           arburst_o,
    output logic                 arvalid_o,
    input  logic                 arready_i,
    input  logic [ID_W-1:0]      rid_i,
    input  logic                 rlast_i,
    input  logic                 rvalid_i,
    output logic                 rready_o,
    output logic [N_REQ-1:0]     rvalid_o,
    input  logic [N_REQ-1:0]     rready_i,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int CNT_W = $clog2(MAX_OUTS + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW    = 41;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_HELD = 1'b1} slot_e;

    slot_e              slot_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [ID_W-1:0]    arid_r;
    logic [DW-1:0]      payload_r;
    logic [CNT_W-1:0]   cnt_r [N_REQ];
    logic               err_r;

    logic [CNT_W-1:0]   cnt_nxt_s [N_REQ];
    logic [N_REQ-1:0]   elig_s;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               ar_hs_s;
    logic               slot_free_s;
    logic               grant_s;
    logic               rid_ok_s;
    logic               r_sel_ready_s;
    logic               r_last_hs_s;
    logic               err_set_s;
    logic               all_zero_s;
    logic [DW-1:0]      win_data_s;

    assign arvalid_o   = (slot_r == SLOT_HELD);
    assign arid_o      = arid_r;
    assign araddr_o    = payload_r[40:9];
    assign arlen_o     = payload_r[8:5];
    assign arsize_o    = payload_r[4:2];
    assign arburst_o   = payload_r[1:0];
    assign err_o       = err_r;
    assign ar_hs_s     = arvalid_o & arready_i;
    assign slot_free_s = ~arvalid_o | arready_i;
    assign grant_s     = ~rst & slot_free_s & win_found_s;

    // Eligibility counts the AR still sitting in the slot so the cap holds under back-to-back grants.
    always_comb begin
        logic [CNT_W:0] eff;
        eff = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eff = {1'b0, cnt_r[i]} +
                  {{CNT_W{1'b0}}, (arvalid_o && (arid_r == ID_W'(i)))};
            elig_s[i] = req_valid_i[i] && (eff < (CNT_W + 1)'(MAX_OUTS));
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        int j;
        j           = 0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr_r) + k) % N_REQ;
            if (!win_found_s && elig_s[j]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(j);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Winner payload select and one-hot accept strobe.
    always_comb begin
        win_data_s = req_data_i[int'(win_idx_s) * DW +: DW];
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = grant_s && (win_idx_s == IDX_W'(i));
        end
    end

    // R steering: unknown IDs are drained so the interconnect never stalls on them.
    always_comb begin
        rid_ok_s      = ({1'b0, rid_i} < (ID_W + 1)'(N_REQ));
        r_sel_ready_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rvalid_o[i] = rvalid_i && (rid_i == ID_W'(i));
            if (rid_i == ID_W'(i)) begin
                r_sel_ready_s = rready_i[i];
            end else begin
                r_sel_ready_s = r_sel_ready_s;
            end
        end
        rready_o    = rid_ok_s ? r_sel_ready_s : 1'b1;
        r_last_hs_s = rvalid_i && rready_o && rlast_i;
    end

    // Outstanding counters; a simultaneous issue and retire on one ID cancel out.
    always_comb begin
        logic inc;
        logic dec;
        inc        = 1'b0;
        dec        = 1'b0;
        err_set_s  = rvalid_i && !rid_ok_s;
        all_zero_s = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            inc = ar_hs_s && (arid_r == ID_W'(i));
            dec = r_last_hs_s && rid_ok_s && (rid_i == ID_W'(i));
            cnt_nxt_s[i] = cnt_r[i];
            if (inc && !dec) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_r[i] == '0) begin
                    err_set_s = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            if (cnt_r[i] != '0) begin
                all_zero_s = 1'b0;
            end else begin
                all_zero_s = all_zero_s;
            end
        end
        idle_o = ~arvalid_o & all_zero_s;
    end

    // AR slot state machine, pointer, counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r    <= SLOT_EMPTY;
            ptr_r     <= IDX_W'(N_REQ - 1);
            arid_r    <= '0;
            payload_r <= '0;
            err_r     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            case (slot_r)
                SLOT_EMPTY, SLOT_HELD: begin
                    if (grant_s) begin
                        slot_r    <= SLOT_HELD;
                        arid_r    <= ID_W'(win_idx_s);
                        payload_r <= win_data_s;
                        ptr_r     <= win_idx_s;
                    end else if (ar_hs_s) begin
                        slot_r <= SLOT_EMPTY;
                    end else begin
                        slot_r <= slot_r;
                    end
                end
                default: slot_r <= SLOT_EMPTY;
            endcase
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_sgdmac_ar_scheduler.sv
// Randomised and directed bench for sgdmac_ar_scheduler; a round-robin reference model
// predicts grants and R routing, and a monitor scoreboards every AR handshake.
module tb_sgdmac_ar_scheduler;
    localparam int N_REQ    = 2;
    localparam int MAX_OUTS = 4;
    localparam int ID_W     = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid_i, req_ready_o, rvalid_o, rready_i;
    logic [N_REQ*41-1:0] req_data_i;
    logic [ID_W-1:0]     arid_o, rid_i;
    logic [31:0]         araddr_o;
    logic [3:0]          arlen_o;
    logic [2:0]          arsize_o;
    logic [1:0]          arburst_o;
    logic                arvalid_o, arready_i, rlast_i, rvalid_i, rready_o, idle_o, err_o;

    always #5 clk = ~clk;

    sgdmac_ar_scheduler #(.N_REQ(N_REQ), .MAX_OUTS(MAX_OUTS), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
        .arready_i(arready_i), .rid_i(rid_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .idle_o(idle_o), .err_o(err_o));

    typedef struct {
        int          id;
        logic [40:0] pl;
    } ar_t;

    int   total = 0;
    int   bad   = 0;
    ar_t  ar_q[$];
    int   dut_ids[$];
    int   dut_hs0 = 0;

    // reference model state
    int          m_ptr, m_held, m_id, m_err;
    int          m_cnt [N_REQ];
    logic [40:0] m_pl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = N_REQ - 1;
        m_held = 0;
        m_id   = 0;
        m_err  = 0;
        m_pl   = '0;
        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        ar_q.delete();
        dut_ids.delete();
        dut_hs0 = 0;
    endtask

    task automatic step(input logic r, input logic [N_REQ-1:0] rv, input logic ard,
                        input logic rvi, input int rid, input logic rl,
                        input logic [N_REQ-1:0] rri);
        logic [40:0]      pl [N_REQ];
        logic [N_REQ-1:0] exp_rdy, exp_rvo;
        logic             exp_rro, hs, free, rok, rdone, inc, dec;
        int               win, j, eff;
        ar_t              e;
        @(negedge clk);
        rst = r; req_valid_i = rv; arready_i = ard; rvalid_i = rvi;
        rid_i = ID_W'(rid); rlast_i = rl; rready_i = rri;
        for (int i = 0; i < N_REQ; i++) begin
            pl[i] = {$urandom, 9'($urandom)};
            req_data_i[i*41 +: 41] = pl[i];
        end
        #1;
        hs   = (m_held != 0) && ard;
        free = (m_held == 0) || ard;
        win  = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            j   = (m_ptr + k) % N_REQ;
            eff = m_cnt[j] + (((m_held != 0) && (m_id == j)) ? 1 : 0);
            if (win < 0 && rv[j] && eff < MAX_OUTS) win = j;
        end
        exp_rdy = '0;
        if (!r && free && win >= 0) exp_rdy[win] = 1'b1;
        rok     = (rid < N_REQ);
        exp_rvo = '0;
        if (rvi && rok) exp_rvo[rid] = 1'b1;
        exp_rro = rok ? rri[rid] : 1'b1;
        rdone   = rvi && exp_rro && rl;

        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("arvalid", 64'(arvalid_o), 64'(m_held));
        chk("arid", 64'(arid_o), 64'(m_id));
        chk("ar_payload", 64'({araddr_o, arlen_o, arsize_o, arburst_o}), 64'(m_pl));
        chk("idle", 64'(idle_o), 64'((m_held == 0) && (m_cnt.sum() == 0)));
        chk("err", 64'(err_o), 64'(m_err));
        chk("rvalid_o", 64'(rvalid_o), 64'(exp_rvo));
        chk("rready_o", 64'(rready_o), 64'(exp_rro));
        if (exp_rdy != '0) begin
            e.id = win;
            e.pl = pl[win];
            ar_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (rvi && !rok) m_err = 1;
            for (int i = 0; i < N_REQ; i++) begin
                inc = hs && (m_id == i);
                dec = rdone && rok && (rid == i);
                if (inc && !dec) m_cnt[i]++;
                else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1;
                    else m_cnt[i]--;
                end
            end
            if (free) begin
                if (win >= 0) begin
                    m_held = 1; m_id = win; m_pl = pl[win]; m_ptr = win;
                end else begin
                    m_held = 0;
                end
            end
        end
    endtask

    // AR monitor: pops the scoreboard on every accepted AR
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            #2;
            if (arvalid_o === 1'b1 && arready_i === 1'b1 && rst === 1'b0) begin
                dut_ids.push_back(int'(arid_o));
                if (arid_o == '0) dut_hs0++;
                if (ar_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ar_unexpected: got id %0d expected no AR at %0t", arid_o, $time);
                end else begin
                    e = ar_q.pop_front();
                    chk("sb_arid", 64'(arid_o), 64'(e.id));
                    chk("sb_payload", 64'({araddr_o, arlen_o, arsize_o, arburst_o}), 64'(e.pl));
                end
            end
        end
    end

    initial begin
        logic [3:0] order;
        int         rid;
        logic       rvi;
        rst = 1'b1; req_valid_i = '0; arready_i = 1'b0; rvalid_i = 1'b0; rid_i = '0;
        rlast_i = 1'b0; rready_i = '0; req_data_i = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // back-to-back round robin from reset
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        repeat (5) step(1'b0, 2'b11, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        order = 4'hF;
        if (dut_ids.size() >= 4)
            order = {dut_ids[0][0], dut_ids[1][0], dut_ids[2][0], dut_ids[3][0]};
        chk("rr_order", 64'(order), 64'(4'b0101));

        // held slot with arready low
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        repeat (6) step(1'b0, 2'b10, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b10, 1'b1, 1'b0, 0, 1'b0, 2'b00);

        // outstanding cap on requester 0, requester 1 still served
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        repeat (8) step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        chk("cap_hs0", 64'(dut_hs0), 64'(MAX_OUTS));
        repeat (3) step(1'b0, 2'b11, 1'b1, 1'b0, 0, 1'b0, 2'b00);

        // simultaneous AR handshake and RLAST on id 0 with two outstanding
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b00, 1'b1, 1'b1, 0, 1'b1, 2'b01);
        repeat (4) step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);

        // unknown RID drained, sticky error
        step(1'b0, 2'b00, 1'b0, 1'b1, 5, 1'b1, 2'b00);
        repeat (3) step(1'b0, 2'b00, 1'b1, 1'b0, 0, 1'b0, 2'b11);

        // reset mid-burst, then grant restarts at index 0
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        repeat (4) step(1'b0, 2'b01, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        step(1'b1, 2'b01, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b11, 1'b1, 1'b0, 0, 1'b0, 2'b00);
        step(1'b0, 2'b11, 1'b1, 1'b0, 0, 1'b0, 2'b00);

        // random traffic, legal R only
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        for (int c = 0; c < 400; c++) begin
            rid = $urandom_range(N_REQ - 1, 0);
            rvi = ($urandom_range(2, 0) == 0) && (m_cnt[rid] > 0);
            step(($urandom_range(150, 0) == 0), N_REQ'($urandom), 1'($urandom), rvi, rid,
                 1'($urandom), N_REQ'($urandom));
        end

        // random traffic including unknown RIDs and spurious RLASTs
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);
        for (int c = 0; c < 200; c++) begin
            step(($urandom_range(60, 0) == 0), N_REQ'($urandom), 1'($urandom),
                 ($urandom_range(3, 0) == 0), $urandom_range(5, 0), 1'($urandom),
                 N_REQ'($urandom));
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
